fifo_image_filter_img_0_data_stream_1_v_ctrl: RTL and testbench
===============================================================

FIFO_IMAGE_FILTER_IMG_0_DATA_STREAM_1_V_CTRL -- requirements
Module: fifo_image_filter_img_0_data_stream_1_v_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the data word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 1, giving the storage address width; DEPTH <= 2^ADDR_WIDTH.
REQ-003 The block SHALL have parameter DEPTH, default 2, giving the number of storage entries; DEPTH >= 2.
REQ-004 clk  input  1  the only clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 if_din  input  DATA_WIDTH  write data from the upstream producer.
REQ-007 if_write_ce  input  1  write-side clock enable.
REQ-008 if_write  input  1  write request.
REQ-009 if_full_n  output  1  high when the FIFO can accept a word.
REQ-010 if_read_ce  input  1  read-side clock enable.
REQ-011 if_read  input  1  read request (pop).
REQ-012 if_empty_n  output  1  high when if_dout holds a valid word.
REQ-013 if_dout  output  DATA_WIDTH  oldest stored word (head of FIFO).

Function
REQ-014 Storage SHALL be a DEPTH-entry shift register: on an accepted write, entry[i+1] takes entry[i] for all i < DEPTH-1, and entry[0] takes if_din.
REQ-015 Write accepted (wr_acc) SHALL be if_write & if_write_ce & if_full_n; otherwise the storage SHALL hold.
REQ-016 Read accepted (rd_acc) SHALL be if_read & if_read_ce & if_empty_n.
REQ-017 Occupancy pointer mOutPtr SHALL be ADDR_WIDTH+1 bits wide, with all-ones meaning empty; a value of k means k+1 words are stored.
REQ-018 if_dout SHALL be combinationally entry[mOutPtr[ADDR_WIDTH-1:0]], with no added latency.
REQ-019 On wr_acc & !rd_acc: mOutPtr increments by 1 and if_empty_n goes to 1; if_full_n goes to 0 iff the pre-update mOutPtr == DEPTH-2, otherwise it holds.
REQ-020 On rd_acc & !wr_acc: mOutPtr decrements by 1 and if_full_n goes to 1; if_empty_n goes to 0 iff the pre-update mOutPtr == 0, otherwise it holds.
REQ-021 On wr_acc & rd_acc: mOutPtr, if_full_n and if_empty_n SHALL hold, the storage shifts, and if_dout still presents the head word in the following cycle.
REQ-022 When empty, a read request SHALL be ignored; a simultaneous write is treated as write-only.
REQ-023 When full, a write request SHALL be ignored and the storage is unchanged; a simultaneous read is treated as read-only.
REQ-024 First-word latency SHALL be 1 cycle: a word written at edge N is visible on if_dout with if_empty_n=1 after edge N.
REQ-025 if_full_n and if_empty_n SHALL be registered, with no combinational path from any input.
REQ-026 The block SHALL never be empty and full at once; if_full_n | if_empty_n SHALL always be 1.
REQ-027 With ce low, no pointer, flag or storage change SHALL occur regardless of if_write and if_read.

Reset
REQ-028 On reset=1 at a rising edge, mOutPtr SHALL become all-ones, if_empty_n 0, if_full_n 1, and all storage entries 0, so if_dout reads 0.
REQ-029 Reset SHALL take priority over any simultaneous read or write, and in-flight contents SHALL be discarded.
REQ-030 After reset deasserts, the block SHALL accept a write on the first following edge.

Verification (DEPTH=2, DATA_WIDTH=8)
REQ-031 Reset, then idle -> if_empty_n=0, if_full_n=1, if_dout=0x00.
REQ-032 Write 0xA1, then 0xB2 on consecutive cycles -> after edge 1, empty_n=1 and dout=0xA1; after edge 2, full_n=0 and dout=0xA1.
REQ-033 Full with {0xA1,0xB2}, write 0xC3 with no read -> write ignored; reads return 0xA1 then 0xB2, then empty_n=0 and full_n=1.
REQ-034 One word 0x11 held, write 0x22 and read together -> pointer unchanged, empty_n=1, full_n=1, dout=0x22 next cycle.
REQ-035 Empty, read asserted with write 0x5A -> the result is write-only, empty_n=1, dout=0x5A; if_write_ce=0 with if_write=1 -> no change.
REQ-036 Full, assert reset with read and write high -> next cycle empty_n=0, full_n=1, dout=0x00.

Source files
------------

// File: rtl/fifo_image_filter_img_0_data_stream_1_v_ctrl.sv
// Shift-register FIFO with a registered occupancy pointer and registered full/empty flags.
// The newest word enters at entry 0, and the head word is selected by the pointer.
module fifo_image_filter_img_0_data_stream_1_v_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 1,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] if_din,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   output logic                  if_full_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic                  if_empty_n,
   output logic [DATA_WIDTH-1:0] if_dout
);

   localparam logic [ADDR_WIDTH:0] PTR_EMPTY   = '1;
   localparam logic [ADDR_WIDTH:0] PTR_LAST    = (ADDR_WIDTH+1)'(DEPTH - 2);
   localparam logic [ADDR_WIDTH:0] PTR_LAST_RD = '0;

   logic [DATA_WIDTH-1:0] mem_reg  [DEPTH];
   logic [DATA_WIDTH-1:0] shift_in [DEPTH];
   logic [ADDR_WIDTH:0]   out_ptr_reg, out_ptr_next;
   logic                  full_n_reg, full_n_next;
   logic                  empty_n_reg, empty_n_next;
   logic                  wr_acc, rd_acc;

   assign wr_acc = if_write & if_write_ce & full_n_reg;
   assign rd_acc = if_read & if_read_ce & empty_n_reg;

   // Each entry takes its lower neighbour on a write; entry 0 takes the input word.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shift
         if (gi == 0) begin : g_head
            assign shift_in[gi] = if_din;
         end else begin : g_body
            assign shift_in[gi] = mem_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (wr_acc) begin
         mem_reg <= shift_in;
      end
   end

   always_comb begin
      out_ptr_next = out_ptr_reg;
      full_n_next  = full_n_reg;
      empty_n_next = empty_n_reg;
      if (wr_acc && !rd_acc) begin
         out_ptr_next = out_ptr_reg + 1'b1;
         empty_n_next = 1'b1;
         if (out_ptr_reg == PTR_LAST) begin
            full_n_next = 1'b0;
         end
      end else if (rd_acc && !wr_acc) begin
         out_ptr_next = out_ptr_reg - 1'b1;
         full_n_next  = 1'b1;
         if (out_ptr_reg == PTR_LAST_RD) begin
            empty_n_next = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_ptr_reg <= PTR_EMPTY;
         full_n_reg  <= 1'b1;
         empty_n_reg <= 1'b0;
      end else begin
         out_ptr_reg <= out_ptr_next;
         full_n_reg  <= full_n_next;
         empty_n_reg <= empty_n_next;
      end
   end

   assign if_full_n  = full_n_reg;
   assign if_empty_n = empty_n_reg;
   assign if_dout    = mem_reg[out_ptr_reg[ADDR_WIDTH-1:0]];

endmodule

// File: tb/tb_fifo_image_filter_img_0_data_stream_1_v_ctrl.sv
// Bench: queue-based FIFO model checked every cycle, plus literal expectations
// for the directed scenarios.
module tb_fifo_image_filter_img_0_data_stream_1_v_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 1;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] if_din = '0;
   logic          if_write_ce = 1'b0;
   logic          if_write = 1'b0;
   logic          if_full_n;
   logic          if_read_ce = 1'b0;
   logic          if_read = 1'b0;
   logic          if_empty_n;
   logic [DW-1:0] if_dout;

   int errors = 0;
   int checks = 0;

   fifo_image_filter_img_0_data_stream_1_v_ctrl #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .if_din(if_din),
      .if_write_ce(if_write_ce), .if_write(if_write), .if_full_n(if_full_n),
      .if_read_ce(if_read_ce), .if_read(if_read), .if_empty_n(if_empty_n),
      .if_dout(if_dout)
   );

   always #5 clk = ~clk;

   // Behavioural model: a queue of stored words, oldest at the front.
   logic [DW-1:0] model_q[$];
   bit            model_live = 0;
   bit            dout_zero_when_empty = 0;

   always @(posedge clk) begin
      bit wr, rd;
      if (reset) begin
         model_q.delete();
         model_live = 1;
         dout_zero_when_empty = 1;
      end else begin
         wr = if_write && if_write_ce && (model_q.size() < DEPTH);
         rd = if_read && if_read_ce && (model_q.size() > 0);
         if (rd) void'(model_q.pop_front());
         if (wr) begin
            model_q.push_back(if_din);
            dout_zero_when_empty = 0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (model_live) begin
         check("model_empty_n", 32'(if_empty_n), 32'(model_q.size() != 0));
         check("model_full_n", 32'(if_full_n), 32'(model_q.size() != DEPTH));
         check("never_full_and_empty", 32'(if_full_n | if_empty_n), 32'd1);
         if (model_q.size() != 0)
            check("model_dout", 32'(if_dout), 32'(model_q[0]));
         else if (dout_zero_when_empty)
            check("model_dout_zero", 32'(if_dout), 32'd0);
      end
   end

   // Drive one cycle of inputs, let the edge pass, return at the next falling edge.
   task automatic cyc(input bit rst, input bit w, input bit wce, input logic [DW-1:0] d,
                      input bit r, input bit rce);
      reset = rst; if_write = w; if_write_ce = wce; if_din = d;
      if_read = r; if_read_ce = rce;
      @(posedge clk);
      @(negedge clk);
      $display("txn rst=%0d w=%0d wce=%0d din=%02h r=%0d rce=%0d -> empty_n=%0d full_n=%0d dout=%02h",
               rst, w, wce, d, r, rce, if_empty_n, if_full_n, if_dout);
   endtask

   initial begin
      @(negedge clk);
      cyc(1, 0, 0, 8'h00, 0, 0);
      cyc(0, 0, 0, 8'h00, 0, 0);
      check("idle_empty_n", 32'(if_empty_n), 32'd0);
      check("idle_full_n", 32'(if_full_n), 32'd1);
      check("idle_dout", 32'(if_dout), 32'h00);

      cyc(0, 1, 1, 8'hA1, 0, 0);
      check("wr1_empty_n", 32'(if_empty_n), 32'd1);
      check("wr1_dout", 32'(if_dout), 32'hA1);
      cyc(0, 1, 1, 8'hB2, 0, 0);
      check("wr2_full_n", 32'(if_full_n), 32'd0);
      check("wr2_dout", 32'(if_dout), 32'hA1);

      cyc(0, 1, 1, 8'hC3, 0, 0);
      check("full_wr_ignored_dout", 32'(if_dout), 32'hA1);
      cyc(0, 0, 0, 8'h00, 1, 1);
      check("rd1_dout", 32'(if_dout), 32'hB2);
      check("rd1_full_n", 32'(if_full_n), 32'd1);
      cyc(0, 0, 0, 8'h00, 1, 1);
      check("rd2_empty_n", 32'(if_empty_n), 32'd0);
      check("rd2_full_n", 32'(if_full_n), 32'd1);

      cyc(0, 1, 1, 8'h11, 0, 0);
      cyc(0, 1, 1, 8'h22, 1, 1);
      check("rw_dout", 32'(if_dout), 32'h22);
      check("rw_empty_n", 32'(if_empty_n), 32'd1);
      check("rw_full_n", 32'(if_full_n), 32'd1);

      cyc(0, 0, 0, 8'h00, 1, 1);
      cyc(0, 1, 1, 8'h5A, 1, 1);
      check("empty_rw_empty_n", 32'(if_empty_n), 32'd1);
      check("empty_rw_dout", 32'(if_dout), 32'h5A);
      cyc(0, 1, 0, 8'h77, 0, 0);
      check("wce_low_dout", 32'(if_dout), 32'h5A);
      check("wce_low_full_n", 32'(if_full_n), 32'd1);

      cyc(0, 1, 1, 8'h66, 0, 0);
      check("refill_full_n", 32'(if_full_n), 32'd0);
      cyc(1, 1, 1, 8'hEE, 1, 1);
      check("rst_empty_n", 32'(if_empty_n), 32'd0);
      check("rst_full_n", 32'(if_full_n), 32'd1);
      check("rst_dout", 32'(if_dout), 32'h00);

      cyc(0, 1, 1, 8'h99, 0, 0);
      check("post_rst_wr_dout", 32'(if_dout), 32'h99);
      cyc(0, 0, 0, 8'h00, 1, 0);
      check("rce_low_dout", 32'(if_dout), 32'h99);
      check("rce_low_empty_n", 32'(if_empty_n), 32'd1);

      // Mixed traffic, checked against the queue model on every cycle.
      for (int i = 0; i < 60; i++) begin
         cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 8'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
